// File: rtl/game_status.sv
// game_status: score / lives / pellet bookkeeping for the maze game.
//   Tracks the play state (IDLE, PLAY, POWER, DYING, DONE), keeps the
//   saturating binary score, remaining lives and pellets, and times the
//   power-mode and death-freeze windows in video frames.
// Ports:
//   clk_i           system clock, all state changes on rising edge
//   reset_ni        asynchronous active-low reset
//   screen_i[1:0]   screen FSM state (0 title, 1 game, 2 game over)
//   frame_tick_i    one pulse per video frame
//   pellet_eaten_i  normal pellet eaten (pulse)
//   power_eaten_i   power pellet eaten (pulse)
//   ghost_hit_i     Pacman / ghost overlap (pulse)
//   lives_o[1:0]    remaining lives
//   score_o[15:0]   binary score, saturating
//   end_o           one-cycle game-over pulse to the screen FSM
//   power_o         high while in power mode
//   freeze_o        high during the death freeze
//   won_o           last game ended by clearing the maze
module game_status #(
    parameter int START_LIVES  = 3,
    parameter int PELLET_TOTAL = 240,
    parameter int POWER_FRAMES = 360,
    parameter int DEATH_FRAMES = 120
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [1:0]  screen_i,
    input  logic        frame_tick_i,
    input  logic        pellet_eaten_i,
    input  logic        power_eaten_i,
    input  logic        ghost_hit_i,
    output logic [1:0]  lives_o,
    output logic [15:0] score_o,
    output logic        end_o,
    output logic        power_o,
    output logic        freeze_o,
    output logic        won_o
);

    localparam int PW  = $clog2(PELLET_TOTAL + 1);
    localparam int PCW = $clog2(POWER_FRAMES + 1);
    localparam int DCW = $clog2(DEATH_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, PLAY, POWER, DYING, DONE} state_t;

    state_t         state;
    logic [PW-1:0]  pellets;
    logic [PCW-1:0] pwr_cnt;
    logic [DCW-1:0] dth_cnt;

    logic        in_game;
    logic        eat;
    logic        last_pellet;
    logic [7:0]  eat_pts;
    logic [8:0]  add_pts;
    logic [16:0] sum;
    logic [15:0] sat_score;

    // Power wins over a same-cycle normal pellet; the ghost bonus only
    // exists in POWER (in PLAY a hit discards the eat, handled below).
    always_comb begin
        in_game     = (screen_i == 2'd1);
        eat         = pellet_eaten_i | power_eaten_i;
        last_pellet = (pellets == PW'(1));
        eat_pts     = power_eaten_i  ? 8'd50 :
                      pellet_eaten_i ? 8'd10 : 8'd0;
        add_pts     = {1'b0, eat_pts} +
                      ((state == POWER && ghost_hit_i) ? 9'd200 : 9'd0);
        sum         = {1'b0, score_o} + {8'd0, add_pts};
        sat_score   = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            lives_o  <= 2'(START_LIVES);
            score_o  <= '0;
            pellets  <= PW'(PELLET_TOTAL);
            pwr_cnt  <= '0;
            dth_cnt  <= '0;
            end_o    <= 1'b0;
            power_o  <= 1'b0;
            freeze_o <= 1'b0;
            won_o    <= 1'b0;
        end else begin
            end_o <= 1'b0;
            if (state != IDLE && !in_game) begin
                // Leaving the game screen aborts; the cycle's events are dropped
                // and score/lives/won stay visible for the game-over screen.
                state    <= IDLE;
                power_o  <= 1'b0;
                freeze_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_game) begin
                            lives_o  <= 2'(START_LIVES);
                            score_o  <= '0;
                            pellets  <= PW'(PELLET_TOTAL);
                            won_o    <= 1'b0;
                            power_o  <= 1'b0;
                            freeze_o <= 1'b0;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (ghost_hit_i) begin
                            lives_o  <= (lives_o != 2'd0) ? lives_o - 2'd1 : 2'd0;
                            dth_cnt  <= DCW'(DEATH_FRAMES);
                            freeze_o <= 1'b1;
                            state    <= DYING;
                        end else if (eat) begin
                            score_o <= sat_score;
                            if (pellets != '0) pellets <= pellets - PW'(1);
                            if (last_pellet) begin
                                won_o <= 1'b1;
                                end_o <= 1'b1;
                                state <= DONE;
                            end else if (power_eaten_i) begin
                                pwr_cnt <= PCW'(POWER_FRAMES);
                                power_o <= 1'b1;
                                state   <= POWER;
                            end
                        end
                    end
                    POWER: begin
                        if (eat || ghost_hit_i) score_o <= sat_score;
                        if (eat && pellets != '0) pellets <= pellets - PW'(1);
                        // Maze clear beats power reload, which beats expiry.
                        if (eat && last_pellet) begin
                            won_o   <= 1'b1;
                            end_o   <= 1'b1;
                            power_o <= 1'b0;
                            state   <= DONE;
                        end else if (power_eaten_i) begin
                            pwr_cnt <= PCW'(POWER_FRAMES);
                        end else if (frame_tick_i) begin
                            if (pwr_cnt <= PCW'(1)) begin
                                pwr_cnt <= '0;
                                power_o <= 1'b0;
                                state   <= PLAY;
                            end else begin
                                pwr_cnt <= pwr_cnt - PCW'(1);
                            end
                        end
                    end
                    DYING: begin
                        if (frame_tick_i) begin
                            if (dth_cnt <= DCW'(1)) begin
                                dth_cnt  <= '0;
                                freeze_o <= 1'b0;
                                if (lives_o == 2'd0) begin
                                    end_o <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    state <= PLAY;
                                end
                            end else begin
                                dth_cnt <= dth_cnt - DCW'(1);
                            end
                        end
                    end
                    DONE:    ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_status.sv
module tb_game_status;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  screen_a, screen_b;
    logic        tick, pel, pwr, gh;

    logic [1:0]  lives_a, lives_b;
    logic [15:0] score_a, score_b;
    logic        end_a, end_b, power_a, power_b, freeze_a, freeze_b, won_a, won_b;

    always #5 clk = ~clk;

    // A: default parameters. B: one life, four pellets.
    game_status u_a (
        .clk_i(clk), .reset_ni(rst_n), .screen_i(screen_a), .frame_tick_i(tick),
        .pellet_eaten_i(pel), .power_eaten_i(pwr), .ghost_hit_i(gh),
        .lives_o(lives_a), .score_o(score_a), .end_o(end_a), .power_o(power_a),
        .freeze_o(freeze_a), .won_o(won_a)
    );

    game_status #(.START_LIVES(1), .PELLET_TOTAL(4)) u_b (
        .clk_i(clk), .reset_ni(rst_n), .screen_i(screen_b), .frame_tick_i(tick),
        .pellet_eaten_i(pel), .power_eaten_i(pwr), .ghost_hit_i(gh),
        .lives_o(lives_b), .score_o(score_b), .end_o(end_b), .power_o(power_b),
        .freeze_o(freeze_b), .won_o(won_b)
    );

    typedef struct {
        bit          sel;
        string       name;
        logic [1:0]  lives;
        logic [15:0] score;
        logic        power;
        logic        freeze;
        logic        won;
        logic        endo;
        int          endcnt;
    } snap_t;

    snap_t q[$];
    int    total = 0;
    int    passed = 0;
    int    endcnt_a = 0;
    int    endcnt_b = 0;

    // Monitor: counts end_o pulses every cycle, then checks queued snapshots.
    always @(negedge clk) begin
        if (end_a) endcnt_a <= endcnt_a + 1;
        if (end_b) endcnt_b <= endcnt_b + 1;
    end

    always @(negedge clk) begin
        snap_t e, a;
        #0;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = e;
            a.lives  = e.sel ? lives_b  : lives_a;
            a.score  = e.sel ? score_b  : score_a;
            a.power  = e.sel ? power_b  : power_a;
            a.freeze = e.sel ? freeze_b : freeze_a;
            a.won    = e.sel ? won_b    : won_a;
            a.endo   = e.sel ? end_b    : end_a;
            a.endcnt = (e.sel ? endcnt_b : endcnt_a) + ((e.sel ? end_b : end_a) ? 1 : 0);
            total = total + 1;
            if (a.lives === e.lives && a.score === e.score && a.power === e.power &&
                a.freeze === e.freeze && a.won === e.won && a.endo === e.endo &&
                a.endcnt == e.endcnt)
                passed = passed + 1;
            else
                $display("FAIL %s: got lives=%0d score=%0d pwr=%b frz=%b won=%b end=%b ends=%0d, want lives=%0d score=%0d pwr=%b frz=%b won=%b end=%b ends=%0d",
                         e.name, a.lives, a.score, a.power, a.freeze, a.won, a.endo, a.endcnt,
                         e.lives, e.score, e.power, e.freeze, e.won, e.endo, e.endcnt);
        end
    end

    task automatic expect_s(input bit sel, input string name, input int lives, input int score,
                            input bit p, input bit f, input bit w, input bit e, input int ec);
        snap_t s;
        s.sel = sel; s.name = name; s.lives = 2'(lives); s.score = 16'(score);
        s.power = p; s.freeze = f; s.won = w; s.endo = e; s.endcnt = ec;
        q.push_back(s);
    endtask

    // Apply one cycle of pulses; returns #1 after the capturing edge.
    task automatic cyc(input bit p, input bit w, input bit g, input bit t);
        pel = p; pwr = w; gh = g; tick = t;
        @(posedge clk); #1;
        pel = 0; pwr = 0; gh = 0; tick = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 0; screen_a = 0; screen_b = 0; tick = 0; pel = 0; pwr = 0; gh = 0;
        repeat (3) @(posedge clk); #1;
        expect_s(0, "reset_a", 3, 0, 0, 0, 0, 0, 0);
        expect_s(1, "reset_b", 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1;
        cyc(0, 0, 0, 0);

        // ---- DUT A: default parameters ----
        screen_a = 1;
        cyc(0, 0, 0, 0);               expect_s(0, "start", 3, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);    expect_s(0, "pellets3", 3, 30, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0);               expect_s(0, "power_on", 3, 80, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0);               expect_s(0, "power_ghost", 3, 280, 1, 0, 0, 0, 0);
        ticks(359);                    expect_s(0, "power_359", 3, 280, 1, 0, 0, 0, 0);
        ticks(1);                      expect_s(0, "power_expire", 3, 280, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0);               expect_s(0, "hit_with_pellet", 2, 280, 0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0);               expect_s(0, "dying_ignores", 2, 280, 0, 1, 0, 0, 0);
        ticks(119);                    expect_s(0, "freeze_119", 2, 280, 0, 1, 0, 0, 0);
        ticks(1);                      expect_s(0, "freeze_done", 2, 280, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0);               expect_s(0, "pellet_power_same", 2, 330, 1, 0, 0, 0, 0);
        screen_a = 0;
        cyc(1, 0, 1, 0);               expect_s(0, "abort_power", 2, 330, 0, 0, 0, 0, 0);
        screen_a = 1;
        cyc(0, 0, 0, 0);               expect_s(0, "restart", 3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0);               expect_s(0, "restart_hit", 2, 0, 0, 1, 0, 0, 0);
        ticks(5);
        rst_n = 0; #2;                 expect_s(0, "reset_in_dying", 3, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        screen_a = 0; rst_n = 1;
        cyc(0, 0, 0, 0);               expect_s(0, "after_reset", 3, 0, 0, 0, 0, 0, 0);

        screen_a = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);               expect_s(0, "sat_power", 3, 50, 1, 0, 0, 0, 0);
        repeat (330) cyc(0, 0, 1, 0);  expect_s(0, "saturate", 3, 16'hFFFF, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0);               expect_s(0, "sat_hold", 3, 16'hFFFF, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        ticks(359);
        cyc(0, 1, 0, 1);               expect_s(0, "reload_beats_expiry", 3, 16'hFFFF, 1, 0, 0, 0, 0);
        ticks(359);                    expect_s(0, "reload_359", 3, 16'hFFFF, 1, 0, 0, 0, 0);
        ticks(1);                      expect_s(0, "expire2", 3, 16'hFFFF, 0, 0, 0, 0, 0);
        screen_a = 0;
        cyc(0, 0, 0, 0);

        // ---- DUT B: START_LIVES=1, PELLET_TOTAL=4 ----
        screen_b = 1;
        cyc(0, 0, 0, 0);               expect_s(1, "b_start", 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0);               expect_s(1, "b_hit", 0, 0, 0, 1, 0, 0, 0);
        ticks(119);                    expect_s(1, "b_freeze_119", 0, 0, 0, 1, 0, 0, 0);
        ticks(1);                      expect_s(1, "b_death_end", 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0);               expect_s(1, "b_done_hold", 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 1);               expect_s(1, "b_done_ignores", 0, 0, 0, 0, 0, 0, 1);
        screen_b = 0;
        cyc(0, 0, 0, 0);               expect_s(1, "b_idle_hold", 0, 0, 0, 0, 0, 0, 1);
        screen_b = 1;
        cyc(0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);    expect_s(1, "b_pel3", 1, 30, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0);               expect_s(1, "b_win", 1, 40, 0, 0, 1, 1, 2);
        cyc(0, 0, 0, 0);               expect_s(1, "b_win_after", 1, 40, 0, 0, 1, 0, 2);
        screen_b = 0;
        cyc(0, 0, 0, 0);               expect_s(1, "b_idle_won", 1, 40, 0, 0, 1, 0, 2);
        screen_b = 1;
        cyc(0, 0, 0, 0);               expect_s(1, "b_restart", 1, 0, 0, 0, 0, 0, 2);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);               expect_s(1, "b_power_pellets", 1, 70, 1, 0, 0, 0, 2);
        cyc(0, 1, 0, 1);               expect_s(1, "b_win_in_power", 1, 120, 0, 0, 1, 1, 3);
        screen_b = 0;
        cyc(0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total = total + 1;
            $display("FAIL drain: %0d snapshots left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
